// File: rtl/r5fp_int_div_sqrt_mc_if.sv
// rtl/r5fp_int_div_sqrt_mc_if.sv - request/response bundle for the multi-cycle integer div/sqrt unit
interface r5fp_int_div_sqrt_mc_if #(
    parameter int W     = 26,
    parameter int TAG_W = 2
);
    logic             strobe_i;
    logic             is_div_i;
    logic [W-1:0]     N_i;
    logic [W-1:0]     D_i;
    logic [TAG_W-1:0] tag_i;
    logic             kill_i;
    logic [W-1:0]     Quo_o;
    logic [W-1:0]     Rem_o;
    logic             dz_o;
    logic [TAG_W-1:0] tag_o;
    logic             done_o;
    logic             ready_o;

    modport master (
        output strobe_i, is_div_i, N_i, D_i, tag_i, kill_i,
        input  Quo_o, Rem_o, dz_o, tag_o, done_o, ready_o
    );

    modport slave (
        input  strobe_i, is_div_i, N_i, D_i, tag_i, kill_i,
        output Quo_o, Rem_o, dz_o, tag_o, done_o, ready_o
    );
endinterface

// File: rtl/r5fp_int_div_sqrt_mc.sv
// rtl/r5fp_int_div_sqrt_mc.sv - restoring integer divider / square root, R result bits per cycle
module r5fp_int_div_sqrt_mc #(
    parameter int W     = 26,
    parameter int R     = 1,
    parameter int TAG_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    r5fp_int_div_sqrt_mc_if.slave bus
);
    localparam int HW = W / 2;
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] KDIV_M1 = CW'(W / R - 1);
    localparam logic [CW-1:0] KSQ_M1  = CW'(W / (2 * R) - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q;
    logic             dz_q;
    logic [W-1:0]     a_q;      // dividend shifting out / quotient shifting in, or radicand
    logic [W-1:0]     d_q;      // divisor
    logic [W-1:0]     rem_q;    // partial remainder (always fits W bits between iterations)
    logic [HW-1:0]    root_q;
    logic [TAG_W-1:0] tag_q;

    logic [W-1:0]     quo_res_q;
    logic [W-1:0]     rem_res_q;
    logic             dz_res_q;
    logic [TAG_W-1:0] tag_res_q;

    logic [W-1:0]     a_n;
    logic [W-1:0]     rem_n;
    logic [HW-1:0]    root_n;
    logic [W:0]       pr;
    logic [W:0]       trial;
    logic             start;
    logic             finish;

    // Kill always wins; strobes while busy are dropped.
    assign start  = (state_q != S_BUSY) && bus.strobe_i && !bus.kill_i;
    assign finish = (state_q == S_BUSY) && !bus.kill_i && (cnt_q == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = start ? S_BUSY : S_IDLE;
            S_BUSY: begin
                if (bus.kill_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // R unrolled restoring iterations; the wide pr carries the extra compare bit.
    always_comb begin
        a_n    = a_q;
        rem_n  = rem_q;
        root_n = root_q;
        pr     = '0;
        trial  = '0;
        for (int i = 0; i < R; i++) begin
            if (is_div_q) begin
                pr  = {rem_n, a_n[W-1]};
                a_n = a_n << 1;
                if (pr >= {1'b0, d_q}) begin
                    pr     = pr - {1'b0, d_q};
                    a_n[0] = 1'b1;
                end
            end else begin
                // Sqrt remainder stays below 2^(HW+1), so its top bits are free for the shift.
                pr             = {rem_n[W-2:0], a_n[W-1:W-2]};
                a_n            = a_n << 2;
                trial          = '0;
                trial[HW+1:0]  = {root_n, 2'b01};
                root_n         = root_n << 1;
                if (pr >= trial) begin
                    pr        = pr - trial;
                    root_n[0] = 1'b1;
                end
            end
            rem_n = pr[W-1:0];
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            a_q       <= '0;
            d_q       <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            tag_q     <= '0;
            quo_res_q <= '0;
            rem_res_q <= '0;
            dz_res_q  <= 1'b0;
            tag_res_q <= '0;
        end else if (start) begin
            is_div_q <= bus.is_div_i;
            dz_q     <= bus.is_div_i && (bus.D_i == '0);
            a_q      <= bus.is_div_i ? bus.N_i : bus.D_i;
            d_q      <= bus.D_i;
            rem_q    <= '0;
            root_q   <= '0;
            tag_q    <= bus.tag_i;
            if (bus.is_div_i && (bus.D_i == '0)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= bus.is_div_i ? KDIV_M1 : KSQ_M1;
            end
        end else if (state_q == S_BUSY) begin
            a_q    <= a_n;
            rem_q  <= rem_n;
            root_q <= root_n;
            cnt_q  <= cnt_q - CNT_ONE;
            if (finish) begin
                tag_res_q <= tag_q;
                dz_res_q  <= dz_q;
                if (dz_q) begin
                    quo_res_q <= '1;
                    rem_res_q <= a_q;
                end else if (is_div_q) begin
                    quo_res_q <= a_n;
                    rem_res_q <= rem_n;
                end else begin
                    quo_res_q <= {{(W-HW){1'b0}}, root_n};
                    rem_res_q <= rem_n;
                end
            end
        end
    end

    assign bus.Quo_o   = quo_res_q;
    assign bus.Rem_o   = rem_res_q;
    assign bus.dz_o    = dz_res_q;
    assign bus.tag_o   = tag_res_q;
    assign bus.done_o  = (state_q == S_DONE);
    assign bus.ready_o = (state_q != S_BUSY);
endmodule

// File: tb/tb_r5fp_int_div_sqrt_mc.sv
// tb/tb_r5fp_int_div_sqrt_mc.sv - directed bench for r5fp_int_div_sqrt_mc at W=8, R=1/2/4
module tb_r5fp_int_div_sqrt_mc;
    localparam int W     = 8;
    localparam int TAG_W = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    r5fp_int_div_sqrt_mc_if #(.W(W), .TAG_W(TAG_W)) bus1 ();
    r5fp_int_div_sqrt_mc_if #(.W(W), .TAG_W(TAG_W)) bus2 ();
    r5fp_int_div_sqrt_mc_if #(.W(W), .TAG_W(TAG_W)) bus4 ();

    r5fp_int_div_sqrt_mc #(.W(W), .R(1), .TAG_W(TAG_W)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    r5fp_int_div_sqrt_mc #(.W(W), .R(2), .TAG_W(TAG_W)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
    r5fp_int_div_sqrt_mc #(.W(W), .R(4), .TAG_W(TAG_W)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

    int n_pass  = 0;
    int n_total = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic issue2(input logic is_div, input logic [7:0] n, input logic [7:0] d,
                          input logic [1:0] tag);
        bus2.strobe_i = 1'b1;
        bus2.is_div_i = is_div;
        bus2.N_i      = n;
        bus2.D_i      = d;
        bus2.tag_i    = tag;
    endtask

    task automatic wait_done2(input int n0, output int n);
        n = n0;
        do begin
            step();
            n++;
        end while (!bus2.done_o && n < 30);
    endtask

    task automatic no_done2(input string tag);
        int dn = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus2.done_o) dn++;
        end
        chk(tag, dn, 0);
    endtask

    // Run one operation on all three DUTs and compare against a behavioural model.
    task automatic sweep_op(input logic is_div, input logic [7:0] n, input logic [7:0] d);
        int         lat [3];
        logic [7:0] q   [3];
        logic [7:0] r   [3];
        logic       dz  [3];
        int         rr  [3];
        int         eq, er, k, root;
        logic       edz;
        rr[0] = 1; rr[1] = 2; rr[2] = 4;
        if (is_div && d == 0) begin
            eq = 255; er = n; edz = 1'b1;
        end else if (is_div) begin
            eq = n / d; er = n % d; edz = 1'b0;
        end else begin
            root = 0;
            while ((root + 1) * (root + 1) <= d) root++;
            eq = root; er = d - root * root; edz = 1'b0;
        end
        bus1.strobe_i = 1'b1; bus1.is_div_i = is_div; bus1.N_i = n; bus1.D_i = d; bus1.tag_i = 2'd1;
        bus2.strobe_i = 1'b1; bus2.is_div_i = is_div; bus2.N_i = n; bus2.D_i = d; bus2.tag_i = 2'd2;
        bus4.strobe_i = 1'b1; bus4.is_div_i = is_div; bus4.N_i = n; bus4.D_i = d; bus4.tag_i = 2'd3;
        step();
        bus1.strobe_i = 1'b0; bus2.strobe_i = 1'b0; bus4.strobe_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1; q[i] = '0; r[i] = '0; dz[i] = 1'b0;
        end
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bus1.done_o && lat[0] < 0) begin lat[0] = c; q[0] = bus1.Quo_o; r[0] = bus1.Rem_o; dz[0] = bus1.dz_o; end
            if (bus2.done_o && lat[1] < 0) begin lat[1] = c; q[1] = bus2.Quo_o; r[1] = bus2.Rem_o; dz[1] = bus2.dz_o; end
            if (bus4.done_o && lat[2] < 0) begin lat[2] = c; q[2] = bus4.Quo_o; r[2] = bus4.Rem_o; dz[2] = bus4.dz_o; end
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
        end
        for (int i = 0; i < 3; i++) begin
            k = edz ? 1 : (is_div ? W / rr[i] : W / (2 * rr[i]));
            chk($sformatf("sweep_r%0d_%s_n%0d_d%0d_lat", rr[i], is_div ? "div" : "sqrt", n, d), lat[i], k);
            chk($sformatf("sweep_r%0d_%s_n%0d_d%0d_quo", rr[i], is_div ? "div" : "sqrt", n, d), {24'd0, q[i]}, eq);
            chk($sformatf("sweep_r%0d_%s_n%0d_d%0d_rem", rr[i], is_div ? "div" : "sqrt", n, d), {24'd0, r[i]}, er);
            chk($sformatf("sweep_r%0d_%s_n%0d_d%0d_dz", rr[i], is_div ? "div" : "sqrt", n, d), {31'd0, dz[i]}, {31'd0, edz});
        end
    endtask

    initial begin
        int n;
        bus1.strobe_i = 0; bus1.is_div_i = 0; bus1.N_i = 0; bus1.D_i = 0; bus1.tag_i = 0; bus1.kill_i = 0;
        bus2.strobe_i = 0; bus2.is_div_i = 0; bus2.N_i = 0; bus2.D_i = 0; bus2.tag_i = 0; bus2.kill_i = 0;
        bus4.strobe_i = 0; bus4.is_div_i = 0; bus4.N_i = 0; bus4.D_i = 0; bus4.tag_i = 0; bus4.kill_i = 0;
        step();
        step();
        reset = 1'b0;

        chk("rst_ready", bus2.ready_o, 1);
        chk("rst_done",  bus2.done_o,  0);
        chk("rst_quo",   bus2.Quo_o,   0);
        chk("rst_rem",   bus2.Rem_o,   0);
        chk("rst_dz",    bus2.dz_o,    0);
        chk("rst_tag",   bus2.tag_o,   0);

        issue2(1, 200, 7, 2); step(); bus2.strobe_i = 0;
        wait_done2(0, n);
        chk("div200_7_lat", n, 4);
        chk("div200_7_quo", bus2.Quo_o, 28);
        chk("div200_7_rem", bus2.Rem_o, 4);
        chk("div200_7_dz",  bus2.dz_o, 0);
        chk("div200_7_tag", bus2.tag_o, 2);
        step();

        issue2(0, 0, 200, 1); step(); bus2.strobe_i = 0;
        wait_done2(0, n);
        chk("sqrt200_lat", n, 2);
        chk("sqrt200_quo", bus2.Quo_o, 14);
        chk("sqrt200_rem", bus2.Rem_o, 4);
        chk("sqrt200_tag", bus2.tag_o, 1);
        step();

        issue2(0, 8'hAA, 0, 0); step(); bus2.strobe_i = 0;
        wait_done2(0, n);
        chk("sqrt0_lat", n, 2);
        chk("sqrt0_quo", bus2.Quo_o, 0);
        chk("sqrt0_rem", bus2.Rem_o, 0);
        step();

        issue2(0, 0, 255, 3); step(); bus2.strobe_i = 0;
        wait_done2(0, n);
        chk("sqrt255_quo", bus2.Quo_o, 15);
        chk("sqrt255_rem", bus2.Rem_o, 30);
        step();

        issue2(1, 8'h55, 0, 1); step(); bus2.strobe_i = 0;
        wait_done2(0, n);
        chk("dz_lat", n, 1);
        chk("dz_quo", bus2.Quo_o, 8'hFF);
        chk("dz_rem", bus2.Rem_o, 8'h55);
        chk("dz_flag", bus2.dz_o, 1);
        chk("dz_tag", bus2.tag_o, 1);
        step();

        issue2(1, 9, 3, 2); step(); bus2.strobe_i = 0;
        wait_done2(0, n);
        chk("div9_3_lat", n, 4);
        chk("div9_3_quo", bus2.Quo_o, 3);
        chk("div9_3_rem", bus2.Rem_o, 0);
        chk("div9_3_dz",  bus2.dz_o, 0);
        step();

        // Back-to-back: strobe in every DONE cycle, with one stray strobe while busy.
        issue2(1, 255, 1, 0); step(); bus2.strobe_i = 0;
        step();
        issue2(0, 0, 4, 3); step(); bus2.strobe_i = 0;
        bus2.is_div_i = 1; bus2.N_i = 255; bus2.D_i = 1;
        n = 2;
        for (int i = 0; i < 4; i++) begin
            wait_done2(n, n);
            chk($sformatf("b2b%0d_lat", i), n, (i % 2 == 0) ? 4 : 2);
            chk($sformatf("b2b%0d_quo", i), bus2.Quo_o, (i % 2 == 0) ? 255 : 12);
            chk($sformatf("b2b%0d_rem", i), bus2.Rem_o, 0);
            chk($sformatf("b2b%0d_tag", i), bus2.tag_o, i);
            chk($sformatf("b2b%0d_ready_in_done", i), bus2.ready_o, 1);
            if (i < 3) begin
                if (i % 2 == 0) issue2(0, 0, 144, 2'(i + 1));
                else            issue2(1, 255, 1, 2'(i + 1));
            end
            step();
            bus2.strobe_i = 0;
            chk($sformatf("b2b%0d_pulse", i), bus2.done_o, 0);
            chk($sformatf("b2b%0d_next_ready", i), bus2.ready_o, (i < 3) ? 0 : 1);
            n = 0;
        end

        // Kill in the second busy cycle.
        issue2(1, 100, 3, 1); step(); bus2.strobe_i = 0;
        step();
        bus2.kill_i = 1; step(); bus2.kill_i = 0;
        chk("kill_ready", bus2.ready_o, 1);
        chk("kill_done",  bus2.done_o, 0);
        chk("kill_quo",   bus2.Quo_o, 12);
        chk("kill_rem",   bus2.Rem_o, 0);
        chk("kill_tag",   bus2.tag_o, 3);
        chk("kill_dz",    bus2.dz_o, 0);
        no_done2("kill_no_done");

        // Kill and strobe together in IDLE.
        issue2(1, 100, 3, 2); bus2.kill_i = 1; step(); bus2.strobe_i = 0; bus2.kill_i = 0;
        chk("killstrobe_ready", bus2.ready_o, 1);
        no_done2("killstrobe_no_done");
        chk("killstrobe_tag", bus2.tag_o, 3);

        // Reset while busy.
        issue2(1, 100, 3, 2); step(); bus2.strobe_i = 0;
        step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("rstbusy_ready", bus2.ready_o, 1);
        chk("rstbusy_done",  bus2.done_o, 0);
        chk("rstbusy_quo",   bus2.Quo_o, 0);
        chk("rstbusy_rem",   bus2.Rem_o, 0);
        chk("rstbusy_dz",    bus2.dz_o, 0);
        chk("rstbusy_tag",   bus2.tag_o, 0);
        no_done2("rstbusy_no_done");

        issue2(1, 100, 3, 2); step(); bus2.strobe_i = 0;
        wait_done2(0, n);
        chk("div100_3_lat", n, 4);
        chk("div100_3_quo", bus2.Quo_o, 33);
        chk("div100_3_rem", bus2.Rem_o, 1);
        step();

        for (int d = 0; d < 256; d++) begin
            sweep_op(1, 8'hFF, 8'(d));
            sweep_op(1, 8'h00, 8'(d));
            sweep_op(1, 8'((d * 37 + 11) & 255), 8'(d));
            sweep_op(1, 8'($urandom_range(0, 255)), 8'(d));
        end
        for (int d = 0; d < 256; d++) begin
            sweep_op(0, 8'($urandom_range(0, 255)), 8'(d));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
